// File: rtl/hilo_mdu_if.sv
// E-stage multiply/divide bus: operation code and operands in, the
// start/busy handshake and the HI/LO read data back out.
`timescale 1ns/1ps

interface hilo_mdu_if;
    logic [3:0]  HLOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] HLOut;

    // Pipeline side: issues operations and reads HI/LO.
    modport master (output HLOp, A, B, input Start, Busy, HLOut);
    // Unit side: accepts operations and reports status and read data.
    modport slave  (input HLOp, A, B, output Start, Busy, HLOut);
endinterface

// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at start and parked in res_hi/res_lo. It is
// committed to HI/LO only when the latency counter expires, so mf
// instructions only ever observe committed values.
`timescale 1ns/1ps

module hilo_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    hilo_mdu_if.slave bus
);
    localparam int DATA_W  = 32;
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;

    logic [DATA_W-1:0] hi_q, lo_q, res_hi_q, res_lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    logic                      is_md, start, is_mult;
    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;
    logic        [DATA_W-1:0]   nxt_hi, nxt_lo;
    logic        [CNT_W-1:0]    cnt_load;

    // Signed division by magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. Working on magnitudes also makes
    // 0x80000000 / -1 come out as 0x80000000 with remainder 0.
    // Returns {remainder, quotient}.
    function automatic logic [2*DATA_W-1:0] div_signed(
        input logic signed [DATA_W-1:0] n,
        input logic signed [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] un, ud, uq, ur, q, r;
        un = n[DATA_W-1] ? DATA_W'(-n) : DATA_W'(n);
        ud = d[DATA_W-1] ? DATA_W'(-d) : DATA_W'(d);
        if (ud == '0) begin
            uq = '0;
            ur = '0;
        end else begin
            uq = un / ud;
            ur = un % ud;
        end
        q = (n[DATA_W-1] ^ d[DATA_W-1]) ? -uq : uq;
        r = n[DATA_W-1] ? -ur : ur;
        return {r, q};
    endfunction

    assign is_md   = (bus.HLOp >= OP_MULT) && (bus.HLOp <= OP_DIVU);
    assign start   = is_md && !busy_q;
    assign is_mult = (bus.HLOp == OP_MULT) || (bus.HLOp == OP_MULTU);

    assign prod_s = $signed({{DATA_W{bus.A[DATA_W-1]}}, bus.A}) *
                    $signed({{DATA_W{bus.B[DATA_W-1]}}, bus.B});
    assign prod_u = {{DATA_W{1'b0}}, bus.A} * {{DATA_W{1'b0}}, bus.B};

    assign cnt_load = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

    // Result of the operation on the bus; divide by zero keeps HI/LO as they are.
    always_comb begin
        nxt_hi = hi_q;
        nxt_lo = lo_q;
        case (bus.HLOp)
            OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
            OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
            OP_DIV:   if (bus.B != '0) {nxt_hi, nxt_lo} = div_signed(bus.A, bus.B);
            OP_DIVU: begin
                if (bus.B != '0) begin
                    nxt_lo = bus.A / bus.B;
                    nxt_hi = bus.A % bus.B;
                end
            end
            default: ;
        endcase
    end

    // Start/run/commit sequencing plus the mt writes accepted while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                hi_q   <= res_hi_q;
                lo_q   <= res_lo_q;
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            res_hi_q <= nxt_hi;
            res_lo_q <= nxt_lo;
            cnt_q    <= cnt_load;
            busy_q   <= 1'b1;
        end else if (bus.HLOp == OP_MTLO) begin
            lo_q <= bus.A;
        end else if (bus.HLOp == OP_MTHI) begin
            hi_q <= bus.A;
        end
    end

    assign bus.Start = start;
    assign bus.Busy  = busy_q;

    // Read port always shows committed HI/LO, never the pending result.
    always_comb begin
        bus.HLOut = '0;
        if (bus.HLOp == OP_MFHI)      bus.HLOut = hi_q;
        else if (bus.HLOp == OP_MFLO) bus.HLOut = lo_q;
    end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the five-stage MIPS pipeline. It executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo from the `HLOp` code produced by the decoder. It holds operands and results across a fixed per-operation latency. It exports `Start`/`Busy` so the hazard unit can stall HI/LO-dependent instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range ≥1.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `HLOp`  in  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mflo, 6 mfhi, 7 mtlo, 8 mthi; 9–15 treated as none.
- `A`  in  32  forwarded rs value (dividend, multiplicand, or mt source).
- `B`  in  32  forwarded rt value (divisor, multiplier).
- `Start`  out  1  combinational; high when `HLOp` is 1–4 and `Busy`=0.
- `Busy`  out  1  registered; high while an operation is in flight.
- `HLOut`  out  32  combinational; HI when `HLOp`=6, LO when `HLOp`=5, else 0.

## Operation
- State: `HI`, `LO` (32 b each), pending `resHI`/`resLO` (32 b each), down-counter `cnt` (width to hold max(MULT_CYCLES, DIV_CYCLES)).
- IDLE (`cnt`=0, `Busy`=0):
  - Start on mult/multu/div/divu: compute result from A/B and latch it into `resHI`/`resLO`; load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - mthi: HI←A at the edge. mtlo: LO←A at the edge.
- RUN (`cnt`≠0, `Busy`=1):
  - `cnt` decrements each edge.
  - At the edge where `cnt`=1: HI←resHI, LO←resLO, `cnt`←0.
- Any `HLOp` in RUN is ignored: no new start and no mt write. The hazard unit must stall such instructions, and the bench flags any non-zero `HLOp` seen while `Busy`=1.
- mf never writes state. `HLOut` reflects the committed HI/LO, never the pending values.
- Arithmetic:
  - mult: signed 32×32→64, HI=upper, LO=lower. multu: unsigned.
  - divu: LO=A/B, HI=A%B, unsigned.
  - div: signed; quotient truncates toward zero; remainder takes the dividend's sign.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - B=0 for div/divu: latency runs normally, and `resHI`/`resLO` are loaded with the current HI/LO, so the registers are unchanged at completion.
- Operands are captured only at Start. Later changes on A/B have no effect.

## Timing
- Reset (async, immediate): HI=0, LO=0, resHI=0, resLO=0, cnt=0, `Busy`=0. `Start` and `HLOut` follow their combinational definitions.
- Reset asserted mid-RUN aborts the operation; the result is discarded.
- Start sampled at edge E0: `Busy`=1 for cycles E0+1 … E0+N, where N is the op latency. HI/LO are updated and `Busy` falls at the same edge, E0+N.
- An mf in the cycle after `Busy` falls reads the new value.
- Back-to-back: a second md op presented in the first cycle with `Busy`=0 starts immediately; there are no dead cycles.
- An mt in the same cycle a RUN completes is impossible, because `Busy`=1 suppresses it.
- `Busy` OR `Start` is the hazard-unit stall term for md/mf/mt instructions in D.

## Test plan
- mult, A=0xFFFFFFFD (−3), B=5 -> `Start`=1 for one cycle, `Busy`=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu with the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- divu, A=7, B=2 -> `Busy` 10 cycles, LO=3, HI=1. div, A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mtlo A=0x1234 while idle -> the next mflo gives `HLOut`=0x1234. mthi presented while `Busy`=1 -> HI unchanged and the bench assertion flags it.
- Preload HI=0xAA, LO=0xBB, then divu with B=0 -> `Busy` 10 cycles, HI=0xAA, LO=0xBB afterwards.
- Start mult, assert `reset` in cycle 3 of RUN -> `Busy`=0 immediately, HI=LO=0, and no late write after reset is released.
- mult completes, then a div starts in the very next cycle -> the div `Start` is accepted with no gap. mfhi after the div completes returns the div remainder, not the mult result.
